elevator_ctrl: RTL and testbench
================================

# elevator_ctrl

Parametrised successor to the single-car elevator FSM. Holds outstanding floor requests in a pending bitmask instead of an ordered queue and serves them in SCAN (collective) order. Models floor-to-floor travel time and door dwell with counters, and rejects out-of-range requests. Sits between the button-panel decoder and the floor indicator / door driver.

## Interface
Parameters:
- NUM_FLOORS, 8: number of floors, numbered 0..NUM_FLOORS-1; must be ≥ 2.
- TRAVEL_CYCLES, 4: clock cycles to move one floor; must be ≥ 1.
- DOOR_CYCLES, 3: clock cycles the door stays open per stop; must be ≥ 1.
- FLOOR_W (localparam): $clog2(NUM_FLOORS).

Ports:
- i_clk  in  1  single clock; all logic on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req_valid  in  1  request strobe; one request per cycle.
- i_req_floor  in  FLOOR_W  requested floor; sampled when i_req_valid=1.
- o_floor  out  FLOOR_W  current floor, registered.
- o_dir  out  2  scan direction: 2'b00 idle, 2'b01 up, 2'b10 down.
- o_moving  out  1  high while in MOVE_UP or MOVE_DOWN.
- o_door_open  out  1  high while in DOOR_OPEN.
- o_pending  out  NUM_FLOORS  registered pending-request bitmask.
- o_req_err  out  1  one-cycle pulse when a request is dropped because i_req_floor ≥ NUM_FLOORS.

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- A request for floor f sets pending[f], with one exception: if the controller is in IDLE or DOOR_OPEN and f == o_floor, the bit is not set.
  - In IDLE, that request enters DOOR_OPEN on the next edge.
  - In DOOR_OPEN, that request reloads the dwell counter.
- Pending update: pending_next = (pending | set_mask) & ~clear_mask. Clear wins when both hit the same floor in the same cycle.
- IDLE:
  - Requests above and below: follow last_dir (reset value up).
  - Only above: MOVE_UP, o_dir=01.
  - Only below: MOVE_DOWN, o_dir=10.
  - Nothing pending: stay; o_dir=00.
- MOVE_x:
  - The travel counter loads TRAVEL_CYCLES-1 on entry and decrements each cycle.
  - At 0, o_floor steps ±1. If pending[new floor] is set, clear it and enter DOOR_OPEN on the same edge; otherwise reload the counter and continue.
- DOOR_OPEN:
  - The dwell counter loads DOOR_CYCLES-1 on entry.
  - At 0, exit: continue in last_dir if any request lies in that direction; else reverse if any request lies the other way; else IDLE.
  - o_dir holds the scan direction during the stop.
- Boundaries:
  - o_floor never goes below 0 or above NUM_FLOORS-1. Direction logic only moves toward a pending floor, so no wrap-around.
  - A request arriving while moving for the floor just passed stays pending and is served on the return sweep.
- Out-of-range requests: pending is unchanged and o_req_err pulses on the next edge.

## Timing
- Reset values: o_floor=0, o_dir=00, o_moving=0, o_door_open=0, o_pending=0, o_req_err=0, state IDLE, last_dir=up, both counters 0.
- Reset asserted mid-move or mid-dwell clears everything immediately (asynchronous). No request survives reset.
- Request latency:
  - Request accepted at edge k: pending visible after edge k.
  - IDLE leaves for MOVE_x at edge k+1.
  - First floor step at edge k+1+TRAVEL_CYCLES; each further floor takes TRAVEL_CYCLES cycles.
- Each stop holds o_door_open=1 for exactly DOOR_CYCLES cycles (longer if extended by a current-floor request). The next move starts on the closing edge.
- Outputs are all registered; no combinational path from inputs to outputs.

## Structure
- elevator_pkg holds:
  - State enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN).
  - Direction encodings (DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10).
- Sub-module elevator_req_reg, parameterised by NUM_FLOORS, owns:
  - The pending bitmask, set/clear logic and range check.
  - any_above / any_below outputs relative to o_floor.
- elevator_ctrl owns the FSM, both counters and last_dir.

## Test plan
Defaults NUM_FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=3, unless stated otherwise.
- Single trip: reset, then at floor 0 request 2 at edge 0 -> o_floor=1 at edge 5, o_floor=2 and o_door_open=1 at edge 9, door closes at edge 12, IDLE with o_dir=00.
- SCAN order: at floor 3 moving up toward 6, request 1 then 5 -> stops at 5, then 6, then reverses, stops at 1; o_pending empties in that order.
- Current-floor request: in IDLE at floor 4, request 4 -> door opens for 3 cycles, no movement. Re-requesting 4 during dwell extends the open time by 3 cycles from that request.
- Out-of-range: with NUM_FLOORS=6, request 7 -> o_req_err=1 for one cycle, o_pending unchanged, state stays IDLE.
- Simultaneous set/clear: request for floor f in the same cycle the car arrives at f -> bit cleared, exactly one door stop.
- Reset mid-move: assert i_rst_n=0 between floors 2 and 3 -> all outputs return to reset values without waiting for a clock edge; after release, the car idles at floor 0.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and encodings for the SCAN elevator controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMoveUp,
    StMoveDown,
    StDoorOpen
  } state_e;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

endpackage

// File: rtl/elevator_req_reg.sv
// Pending-request bitmask: range check, set/clear, and above/below summary
// relative to the car's current floor.
module elevator_req_reg
  import elevator_pkg::*;
#(
  parameter int unsigned  NUM_FLOORS = 8,
  localparam int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  input  logic [FLOOR_W-1:0]    i_req_floor,
  input  logic [FLOOR_W-1:0]    i_cur_floor,
  input  logic                  i_suppress_cur,
  input  logic                  i_clr_en,
  input  logic [FLOOR_W-1:0]    i_clr_floor,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_req_err,
  output logic                  o_cur_hit,
  output logic                  o_any_above,
  output logic                  o_any_below
);

  localparam logic [NUM_FLOORS-1:0] OneHot0 = {{(NUM_FLOORS - 1){1'b0}}, 1'b1};

  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_FLOORS-1:0] set_mask, clr_mask, cur_mask, below_mask, above_mask;
  logic                  req_err_q, in_range;

  // Decode the incoming request and the arrival clear into masks; clear wins.
  always_comb begin
    in_range  = 32'(i_req_floor) < NUM_FLOORS;
    o_cur_hit = i_req_valid && in_range && (i_req_floor == i_cur_floor) && i_suppress_cur;
    set_mask  = (i_req_valid && in_range && !o_cur_hit) ? (OneHot0 << i_req_floor) : '0;
    clr_mask  = i_clr_en ? (OneHot0 << i_clr_floor) : '0;
    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  // Floors strictly below / strictly above the car, as masks.
  always_comb begin
    cur_mask    = OneHot0 << i_cur_floor;
    below_mask  = cur_mask - OneHot0;
    above_mask  = ~(below_mask | cur_mask);
    o_any_below = |(pending_q & below_mask);
    o_any_above = |(pending_q & above_mask);
  end

  // Pending mask and the one-cycle range-error pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_q <= '0;
      req_err_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      req_err_q <= i_req_valid && !in_range;
    end
  end

  assign o_pending = pending_q;
  assign o_req_err = req_err_q;

endmodule

// File: rtl/elevator_ctrl.sv
// Single-car SCAN elevator controller: FSM, travel/dwell counters, last_dir.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned  NUM_FLOORS    = 8,
  parameter int unsigned  TRAVEL_CYCLES = 4,
  parameter int unsigned  DOOR_CYCLES   = 3,
  localparam int unsigned FLOOR_W       = $clog2(NUM_FLOORS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  input  logic [FLOOR_W-1:0]    i_req_floor,
  output logic [FLOOR_W-1:0]    o_floor,
  output logic [1:0]            o_dir,
  output logic                  o_moving,
  output logic                  o_door_open,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_req_err
);

  localparam int unsigned TRAVEL_W = $clog2(TRAVEL_CYCLES + 1);
  localparam int unsigned DOOR_W   = $clog2(DOOR_CYCLES + 1);

  localparam logic [TRAVEL_W-1:0] TravelLoad = TRAVEL_W'(TRAVEL_CYCLES - 1);
  localparam logic [TRAVEL_W-1:0] TravelOne  = TRAVEL_W'(1);
  localparam logic [DOOR_W-1:0]   DoorLoad   = DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [DOOR_W-1:0]   DoorOne    = DOOR_W'(1);
  localparam logic [FLOOR_W-1:0]  FloorOne   = FLOOR_W'(1);

  state_e                state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d, step_floor;
  logic [1:0]            dir_q, dir_d, last_dir_q, last_dir_d;
  logic [TRAVEL_W-1:0]   tcnt_q, tcnt_d;
  logic [DOOR_W-1:0]     dcnt_q, dcnt_d;
  logic [NUM_FLOORS-1:0] pending;
  logic                  suppress_cur, cur_hit, any_above, any_below, clr_en;
  logic                  go_up, go_down, go_idle;

  // A current-floor request only matters while the car is parked.
  assign suppress_cur = (state_q == StIdle) || (state_q == StDoorOpen);
  assign step_floor   = (state_q == StMoveDown) ? floor_q - FloorOne : floor_q + FloorOne;

  elevator_req_reg #(
    .NUM_FLOORS(NUM_FLOORS)
  ) u_req_reg (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req_valid   (i_req_valid),
    .i_req_floor   (i_req_floor),
    .i_cur_floor   (floor_q),
    .i_suppress_cur(suppress_cur),
    .i_clr_en      (clr_en),
    .i_clr_floor   (step_floor),
    .o_pending     (pending),
    .o_req_err     (o_req_err),
    .o_cur_hit     (cur_hit),
    .o_any_above   (any_above),
    .o_any_below   (any_below)
  );

  // Next-state logic: SCAN scheduling, floor stepping and dwell handling.
  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    tcnt_d     = tcnt_q;
    dcnt_d     = dcnt_q;
    clr_en     = 1'b0;
    go_up      = 1'b0;
    go_down    = 1'b0;
    go_idle    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cur_hit) begin
          state_d = StDoorOpen;
          dcnt_d  = DoorLoad;
        end else if (any_above && any_below) begin
          go_up   = (last_dir_q == DIR_UP);
          go_down = (last_dir_q != DIR_UP);
        end else if (any_above) begin
          go_up = 1'b1;
        end else if (any_below) begin
          go_down = 1'b1;
        end
      end
      StMoveUp, StMoveDown: begin
        if (tcnt_q == '0) begin
          floor_d = step_floor;
          // Stop decision uses the registered mask; the same-edge set is cleared anyway.
          if (pending[step_floor]) begin
            clr_en  = 1'b1;
            state_d = StDoorOpen;
            dcnt_d  = DoorLoad;
          end else begin
            tcnt_d = TravelLoad;
          end
        end else begin
          tcnt_d = tcnt_q - TravelOne;
        end
      end
      StDoorOpen: begin
        if (cur_hit) begin
          dcnt_d = DoorLoad;
        end else if (dcnt_q != '0) begin
          dcnt_d = dcnt_q - DoorOne;
        end else if (last_dir_q == DIR_UP) begin
          go_up   = any_above;
          go_down = !any_above && any_below;
          go_idle = !any_above && !any_below;
        end else begin
          go_down = any_below;
          go_up   = !any_below && any_above;
          go_idle = !any_above && !any_below;
        end
      end
      default: state_d = StIdle;
    endcase

    if (go_up) begin
      state_d    = StMoveUp;
      dir_d      = DIR_UP;
      last_dir_d = DIR_UP;
      tcnt_d     = TravelLoad;
    end
    if (go_down) begin
      state_d    = StMoveDown;
      dir_d      = DIR_DOWN;
      last_dir_d = DIR_DOWN;
      tcnt_d     = TravelLoad;
    end
    if (go_idle) begin
      state_d = StIdle;
      dir_d   = DIR_IDLE;
    end
  end

  // State, position, direction and counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      floor_q    <= '0;
      dir_q      <= DIR_IDLE;
      last_dir_q <= DIR_UP;
      tcnt_q     <= '0;
      dcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      tcnt_q     <= tcnt_d;
      dcnt_q     <= dcnt_d;
    end
  end

  assign o_floor     = floor_q;
  assign o_dir       = dir_q;
  assign o_moving    = (state_q == StMoveUp) || (state_q == StMoveDown);
  assign o_door_open = (state_q == StDoorOpen);
  assign o_pending   = pending;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl against a behavioural SCAN model.
module tb_elevator_ctrl;

  localparam int NF  = 8;
  localparam int TC  = 4;
  localparam int DC  = 3;
  localparam int NF2 = 6;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          req_valid, req_valid2;
  logic [2:0]    req_floor, req_floor2;
  logic [2:0]    o_floor, o_floor2;
  logic [1:0]    o_dir, o_dir2;
  logic          o_moving, o_moving2, o_door_open, o_door_open2, o_req_err, o_req_err2;
  logic [NF-1:0] o_pending;
  logic [NF2-1:0] o_pending2;

  always #5 i_clk = ~i_clk;

  elevator_ctrl #(.NUM_FLOORS(NF), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(req_valid), .i_req_floor(req_floor),
    .o_floor(o_floor), .o_dir(o_dir), .o_moving(o_moving), .o_door_open(o_door_open),
    .o_pending(o_pending), .o_req_err(o_req_err)
  );

  elevator_ctrl #(.NUM_FLOORS(NF2), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut6 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(req_valid2), .i_req_floor(req_floor2),
    .o_floor(o_floor2), .o_dir(o_dir2), .o_moving(o_moving2), .o_door_open(o_door_open2),
    .o_pending(o_pending2), .o_req_err(o_req_err2)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: motion is +1/-1/0, m_left counts cycles to the next event.
  int         m_floor, m_motion, m_last, m_left, m_dirout;
  bit         m_door, m_err;
  bit [NF-1:0] m_pend;

  // Observed stop log (floor at each door opening) and door-rise count.
  int  stop_q[$];
  int  door_rises;
  bit  prev_door;

  task automatic model_reset();
    m_floor = 0; m_motion = 0; m_last = 1; m_left = 0; m_dirout = 0;
    m_door = 0; m_err = 0; m_pend = '0; prev_door = 0;
  endtask

  task automatic start_move(input int d);
    m_motion = d; m_last = d; m_left = TC; m_dirout = (d > 0) ? 1 : 2;
  endtask

  task automatic model_step(input bit v, input int f);
    bit inr, hit, above, below;
    bit [NF-1:0] setm, clrm;
    inr   = (f < NF);
    m_err = v && !inr;
    hit   = v && inr && (f == m_floor) && (m_motion == 0);
    setm  = '0;
    clrm  = '0;
    if (v && inr && !hit) setm[f] = 1'b1;
    above = 0;
    below = 0;
    for (int i = 0; i < NF; i++) begin
      if (m_pend[i] && i > m_floor) above = 1;
      if (m_pend[i] && i < m_floor) below = 1;
    end
    if (m_door) begin
      if (hit) m_left = DC;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_door = 0;
          if ((m_last > 0) ? above : below) start_move(m_last);
          else if ((m_last > 0) ? below : above) start_move(-m_last);
          else m_dirout = 0;
        end
      end
    end else if (m_motion != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_floor += m_motion;
        if (m_pend[m_floor]) begin
          clrm[m_floor] = 1'b1;
          m_motion = 0;
          m_door   = 1;
          m_left   = DC;
        end else m_left = TC;
      end
    end else begin
      if (hit) begin m_door = 1; m_left = DC; end
      else if (above && below) start_move(m_last);
      else if (above) start_move(1);
      else if (below) start_move(-1);
      else m_dirout = 0;
    end
    m_pend = (m_pend | setm) & ~clrm;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("floor",   o_floor,     m_floor);
    check("dir",     o_dir,       m_dirout);
    check("moving",  o_moving,    m_motion != 0);
    check("door",    o_door_open, m_door);
    check("pending", o_pending,   m_pend);
    check("req_err", o_req_err,   m_err);
  endtask

  task automatic cycle(input bit v, input int f);
    req_valid = v;
    req_floor = f[2:0];
    @(posedge i_clk);
    model_step(v, f);
    #1;
    req_valid = 1'b0;
    check_all();
    if (o_door_open && !prev_door) begin
      door_rises++;
      stop_q.push_back(int'(o_floor));
    end
    prev_door = o_door_open;
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (!(m_motion == 0 && !m_door && m_pend == '0) && n < budget) begin
      cycle(0, 0);
      n++;
    end
    check("drain_in_budget", n < budget, 1);
  endtask

  initial begin
    int n, k;
    int exp_stops[3];
    req_valid = 0; req_floor = '0; req_valid2 = 0; req_floor2 = '0;
    door_rises = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check_all();
    i_rst_n = 1'b1;

    // Single trip 0 -> 2
    cycle(1, 2);
    for (int e = 1; e <= 12; e++) begin
      cycle(0, 0);
      if (e == 4) check("trip_e4_floor", o_floor, 0);
      if (e == 5) check("trip_e5_floor", o_floor, 1);
      if (e == 9) begin
        check("trip_e9_floor", o_floor, 2);
        check("trip_e9_door", o_door_open, 1);
      end
      if (e == 11) check("trip_e11_door", o_door_open, 1);
      if (e == 12) begin
        check("trip_e12_door", o_door_open, 0);
        check("trip_e12_dir", o_dir, 0);
      end
    end

    // SCAN order: moving up past 3 toward 6, then request 1 and 5
    stop_q.delete();
    cycle(1, 6);
    k = 0;
    while (!(m_floor == 3 && m_motion == 1) && k < 50) begin cycle(0, 0); k++; end
    check("scan_reach3", k < 50, 1);
    cycle(1, 1);
    cycle(0, 0);
    cycle(1, 5);
    run_until_idle(300);
    exp_stops[0] = 5; exp_stops[1] = 6; exp_stops[2] = 1;
    check("scan_nstops", stop_q.size(), 3);
    for (int i = 0; i < 3 && i < stop_q.size(); i++) check("scan_stop", stop_q[i], exp_stops[i]);

    // Current-floor request: go to 4, then request 4 while idle
    cycle(1, 4);
    run_until_idle(300);
    cycle(1, 4);
    n = 0; k = 0;
    while (o_door_open && k < 10) begin n++; cycle(0, 0); k++; end
    check("dwell_len", n, DC);
    check("dwell_floor", o_floor, 4);
    // Re-request during dwell extends by DOOR_CYCLES from the re-request
    cycle(1, 4);
    cycle(0, 0);
    cycle(1, 4);
    n = 0; k = 0;
    while (o_door_open && k < 10) begin n++; cycle(0, 0); k++; end
    check("dwell_ext_len", n, DC);
    check("dwell_ext_floor", o_floor, 4);

    // Simultaneous set/clear on arrival at 7
    cycle(1, 7);
    k = 0;
    while (!(m_motion != 0 && m_left == 1 && m_floor + m_motion == 7) && k < 50) begin
      cycle(0, 0);
      k++;
    end
    check("simul_reach", k < 50, 1);
    cycle(1, 7);
    check("simul_door", o_door_open, 1);
    check("simul_pend7", o_pending[7], 0);
    n = door_rises;
    run_until_idle(100);
    check("simul_one_stop", door_rises - n, 0);
    check("simul_floor", o_floor, 7);

    // Reset mid-move between floors 3 and 2
    cycle(1, 0);
    k = 0;
    while (!(m_floor == 3 && m_motion == -1 && m_left == 2) && k < 80) begin
      cycle(0, 0);
      k++;
    end
    check("rst_reach", k < 80, 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rst_floor", o_floor, 0);
    check("rst_moving", o_moving, 0);
    check("rst_pending", o_pending, 0);
    check("rst_dir", o_dir, 0);
    model_reset();
    @(posedge i_clk);
    #1;
    check_all();
    i_rst_n = 1'b1;
    repeat (4) cycle(0, 0);
    check("rst_idle_floor", o_floor, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) < 25, int'($urandom_range(0, NF - 1)));
    end
    run_until_idle(600);

    // Out-of-range on the 6-floor instance
    req_valid2 = 1'b1; req_floor2 = 3'd7;
    @(posedge i_clk); #1;
    req_valid2 = 1'b0;
    check("oor_err", o_req_err2, 1);
    check("oor_pending", o_pending2, 0);
    check("oor_moving", o_moving2, 0);
    check("oor_dir", o_dir2, 0);
    @(posedge i_clk); #1;
    check("oor_err_pulse", o_req_err2, 0);
    check("oor_still_idle", o_moving2, 0);
    req_valid2 = 1'b1; req_floor2 = 3'd6;
    @(posedge i_clk); #1;
    req_valid2 = 1'b0;
    check("oor6_err", o_req_err2, 1);
    check("oor6_pending", o_pending2, 0);
    req_valid2 = 1'b1; req_floor2 = 3'd5;
    @(posedge i_clk); #1;
    req_valid2 = 1'b0;
    check("inr5_err", o_req_err2, 0);
    check("inr5_pending", o_pending2, 6'b100000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
